// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of two word requesters onto a
// byte-wide UART sender, sending the low (len+1) bytes MSB-first.
module uart_tx_arbiter (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic [1:0]  len0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] data1,
    input  logic [1:0]  len1,
    output logic        ack1,
    input  logic        sender_ready,
    output logic [7:0]  output_data,
    output logic        valid,
    output logic        busy,
    output logic        grant
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        grant_q, grant_d;

    logic        any_req;
    logic        winner;
    logic [31:0] sel_word;
    logic [1:0]  sel_idx;
    logic [7:0]  sel_byte;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            grant_q <= grant_d;
        end
    end

    // On contention the pointer decides; a lone request wins outright.
    assign any_req  = req0 | req1;
    assign winner   = (req0 & req1) ? ptr_q : req1;
    assign sel_word = (state_q == IDLE) ? (winner ? data1 : data0) : word_q;
    assign sel_idx  = (state_q == IDLE) ? (winner ? len1 : len0) : 2'(cnt_q - 2'd1);
    assign sel_byte = sel_word[{sel_idx, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant_d = grant_q;
        if (state_q == IDLE) begin
            if (any_req) begin
                state_d = SEND;
                ptr_d   = ~winner;
                cnt_d   = sel_idx;
                word_d  = sel_word;
                data_d  = sel_byte;
                valid_d = 1'b1;
                ack0_d  = ~winner;
                ack1_d  = winner;
                grant_d = winner;
            end
        end else if (sender_ready) begin
            if (cnt_q == 2'd0) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end else begin
                cnt_d  = 2'(cnt_q - 2'd1);
                data_d = sel_byte;
            end
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign output_data = data_q;
    assign valid       = valid_q;
    assign busy        = (state_q == SEND);
    assign grant       = grant_q;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Reset: reset, synchronous, active-high; clock CLK.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req0  input  1  requester 0 word-send request; held high until ack0 is seen.
REQ-005 data0  input  32  requester 0 word; stable while req0 high.
REQ-006 len0  input  2  requester 0 byte count minus 1 (0 = 1 byte ... 3 = 4 bytes).
REQ-007 ack0  output  1  one-cycle pulse: requester 0 word latched.
REQ-008 req1 / data1 / len1 / ack1  same widths and meaning for requester 1.
REQ-009 sender_ready  input  1  downstream UART sender can accept a byte this cycle.
REQ-010 output_data  output  8  byte presented to sender.
REQ-011 valid  output  1  output_data is valid; byte transfers on a cycle with valid && sender_ready.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 grant  output  1  index of the requester owning the current or most recent word.

Function
REQ-014 States SHALL be IDLE and SEND only; busy = (state == SEND).
REQ-015 In IDLE with at least one req high, the block SHALL, at the next edge, latch the winner's data and len, pulse the winner's ack for exactly one cycle, set grant, set valid=1, present the first byte, and enter SEND; ack and first valid therefore appear 1 cycle after the sampled req.
REQ-016 Arbitration SHALL be round-robin: a priority pointer, reset to 0, names the preferred requester; after granting requester i, the pointer SHALL become 1-i.
REQ-017 Single request: the requester SHALL be granted regardless of the pointer.
REQ-018 Byte order SHALL be MSB-first over the low (len+1) bytes: len=3 sends [31:24],[23:16],[15:8],[7:0]; len=1 sends [15:8],[7:0]; len=0 sends [7:0].
REQ-019 In SEND, valid SHALL stay high and output_data stable until the cycle where sender_ready is high; at that edge, the next byte SHALL be presented.
REQ-020 When the last byte transfers, the block SHALL clear valid and return to IDLE. Arbitration starts in the following cycle, so consecutive words have at least one valid-low cycle between them.
REQ-021 A remaining-byte counter (2 bits) SHALL decrement on each transfer. The word is complete on a transfer with counter 0; no underflow or wrap.
REQ-022 req, data and len SHALL be ignored while in SEND. A request held high through SEND SHALL be arbitrated at the next IDLE cycle.
REQ-023 A requester still holding req high in the cycle ack is high SHALL NOT be re-granted for that word. The block does not sample req outside IDLE, so re-grant occurs only if req is still high at the next IDLE.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle. Each ack SHALL be high for at most one cycle per word.
REQ-025 sender_ready low indefinitely SHALL stall SEND with all outputs held. There is no timeout.

Reset
REQ-026 On reset: state=IDLE, valid=0, output_data=8'h00, ack0=ack1=0, grant=0, busy=0, pointer=0, counter=0, latched word=0.
REQ-027 Reset asserted mid-word SHALL discard the remaining bytes, emit no further valid, and produce no ack. Requests still high after reset deasserts SHALL be arbitrated normally.

Verification
REQ-028 req0=1, data0=32'hDEADBEEF, len0=3, sender_ready=1 constantly -> ack0 pulse at +1 cycle; bytes DE,AD,BE,EF on 4 consecutive valid cycles; valid low at +5; grant=0.
REQ-029 req0 and req1 both high from reset release, each with len=0, data0=32'h11, data1=32'h22, and held high until their ack -> requester 0 first (byte 11), then requester 1 (byte 22); ack0 and ack1 never overlap.
REQ-030 req1 alone, data1=32'h0000ABCD, len1=1, sender_ready toggling 1,0,0,1 -> byte AB held through the two ready-low cycles, then CD; exactly 2 transfers.
REQ-031 Both requesters streaming continuously with len=0 for 6 words -> grants alternate 0,1,0,1,0,1; each word is followed by at least one valid-low cycle.
REQ-032 reset asserted after the second byte of a len=3 word -> next cycle valid=0, output_data=00, busy=0; no further bytes of that word.
REQ-033 req0 high during SEND of a requester 1 word -> no ack0 until requester 1's last byte transfers; ack0 then one IDLE cycle later.
